// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle WIDTH-bit add/subtract engine. One 4-bit ripple-carry adder is
// time-shared across the operand: each RUN cycle it adds one nibble of A and B,
// starting with the least significant nibble. The carry out of that nibble is
// registered and fed back as the carry in for the next nibble, so the carry
// ripples across cycles exactly as it would through a WIDTH-bit ripple adder.
//
// Subtraction is done as a + ~b + 1. B is inverted when it is latched and the
// carry register is preset to 1.
//
// Handshake: start is a request that is accepted only in IDLE, at the rising
// edge where start=1. Starts that arrive while busy=1 (RUN or DONE) are
// dropped; nothing is queued. done is a one-cycle pulse. sum/cout/ovf are
// valid while done=1 and hold until the next accepted start. They change
// nibble by nibble while busy=1 and must not be used then.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous active-high reset
//   start     in   1      operation request, sampled in IDLE only
//   sub       in   1      0: a + b + cin, 1: a - b
//   in_a      in   WIDTH  operand A, latched on accept
//   in_b      in   WIDTH  operand B, latched on accept
//   cin       in   1      carry in for add, latched on accept
//   busy      out  1      high in RUN and DONE
//   done      out  1      one-cycle result-valid pulse
//   sum       out  WIDTH  result register
//   cout      out  1      final carry out (sub: 1 = no borrow)
//   ovf       out  1      signed overflow of the full-width operation
//   state_dbg out  2      current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------

// 4-bit ripple-carry adder: s = a + b + ci, co is the carry out of bit 3.
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);
  localparam int N  = WIDTH / 4;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [3:0]        nib_a;
  logic [3:0]        nib_b;
  logic [3:0]        add_s;
  logic              add_co;
  logic              last_nib;

  // Select the current nibble of each operand. A constant-index loop keeps the
  // mux explicit and avoids variable part-selects.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  ripple_carry_adder_4bit u_adder (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co)
  );

  assign last_nib = (idx_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = sub ? ~in_b : in_b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IW'(i)) sum_d[4*i +: 4] = add_s;
        end
        carry_d = add_co;
        if (last_nib) begin
          // add_s[3] is the result MSB. b_q is already inverted for subtract,
          // so one rule covers both add and subtract.
          idx_d   = '0;
          cout_d  = add_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[3] != a_q[WIDTH-1]);
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// Bench for nibble_serial_adder. One 16-bit and one 32-bit instance share
// clk/rst. Expected {cout, ovf, sum} entries are queued when an operation is
// started. A negedge monitor per instance pops one entry on every done pulse.
// Inputs are driven at negedge and outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 16-bit instance
  logic        start, sub, cin;
  logic [15:0] in_a, in_b;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;
  logic [1:0]  state_dbg;

  // 32-bit instance
  logic        start_w, sub_w, cin_w;
  logic [31:0] in_a_w, in_b_w;
  logic        busy_w, done_w, cout_w, ovf_w;
  logic [31:0] sum_w;
  logic [1:0]  state_dbg_w;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .in_a(in_a), .in_b(in_b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .state_dbg(state_dbg)
  );

  nibble_serial_adder #(.WIDTH(32)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .sub(sub_w), .in_a(in_a_w), .in_b(in_b_w),
    .cin(cin_w), .busy(busy_w), .done(done_w), .sum(sum_w), .cout(cout_w), .ovf(ovf_w),
    .state_dbg(state_dbg_w)
  );

  int n_cmp = 0;
  int n_err = 0;

  // {cout, ovf, sum[31:0]}
  logic [33:0] exp_q[$];
  logic [33:0] exp_w_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on wide integers. Add uses the carry at bit w.
  // Subtract is a true difference, so borrow is the sign of the 64-bit result.
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic c,
                                        input logic s);
    logic [63:0] ea, eb, r, mask;
    logic        sa, sb, sr, co, ov;
    ea   = {32'd0, a};
    eb   = {32'd0, b};
    mask = (64'd1 << w) - 64'd1;
    if (!s) r = ea + eb + {63'd0, c};
    else    r = ea - eb;
    sa = ea[w-1];
    sb = eb[w-1];
    sr = r[w-1];
    if (!s) begin
      co = r[w];
      ov = (sa == sb) && (sr != sa);
    end else begin
      co = ~r[63];
      ov = (sa != sb) && (sr != sa);
    end
    r = r & mask;
    return {co, ov, r[31:0]};
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("sum",  {48'd0, sum},  {48'd0, e[15:0]});
        check("cout", {63'd0, cout}, {63'd0, e[33]});
        check("ovf",  {63'd0, ovf},  {63'd0, e[32]});
      end
    end
  end

  always @(negedge clk) begin
    if (done_w === 1'b1) begin
      if (exp_w_q.size() == 0) begin
        check("spurious_done_w", {63'd0, done_w}, 64'd0);
      end else begin
        logic [33:0] e;
        e = exp_w_q.pop_front();
        check("sum_w",  {32'd0, sum_w},  {32'd0, e[31:0]});
        check("cout_w", {63'd0, cout_w}, {63'd0, e[33]});
        check("ovf_w",  {63'd0, ovf_w},  {63'd0, e[32]});
      end
    end
  end

  // Driver: pulse start for one cycle. The task returns at the negedge after
  // the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s, input bit push);
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    if (push) exp_q.push_back(model(16, {16'd0, a}, {16'd0, b}, c, s));
    @(negedge clk);
    start = 1'b0;
    in_a  = $urandom_range(0, 16'hFFFF);
    in_b  = $urandom_range(0, 16'hFFFF);
    cin   = $urandom_range(0, 1);
    sub   = $urandom_range(0, 1);
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // Wait, with a bound, for done. Checks the latency and that busy stays high
  // until done. It then checks that done drops and busy clears one cycle
  // later. If poke_done is set, it raises start during the DONE cycle; that
  // start must be ignored.
  task automatic wait_done(input int exp_lat, input bit poke_done);
    int lat = 0;
    bit seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      check("busy_in_run", {63'd0, busy}, 64'd1);
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    check("latency", lat, exp_lat);
    check("busy_in_done", {63'd0, busy}, 64'd1);
    if (poke_done) begin
      in_a  = 16'h2222;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_end", {63'd0, done}, 64'd0);
    check("busy_cleared", {63'd0, busy}, 64'd0);
    check("state_idle", {62'd0, state_dbg}, 64'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s);
    start_op(a, b, c, s, 1'b1);
    wait_done(4, 1'b0);
  endtask

  task automatic run_op_w(input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s);
    int  lat = 0;
    bit  seen = 0;
    @(negedge clk);
    in_a_w  = a;
    in_b_w  = b;
    cin_w   = c;
    sub_w   = s;
    start_w = 1'b1;
    exp_w_q.push_back(model(32, a, b, c, s));
    @(negedge clk);
    start_w = 1'b0;
    in_a_w  = $urandom;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (done_w === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("done_seen_w", {63'd0, seen}, 64'd1);
    check("latency_w", lat, 8);
    @(negedge clk);
    check("busy_cleared_w", {63'd0, busy_w}, 64'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0; sub   = 1'b0; cin   = 1'b0; in_a   = '0; in_b   = '0;
    start_w = 1'b0; sub_w = 1'b0; cin_w = 1'b0; in_a_w = '0; in_b_w = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_done",  {63'd0, done}, 64'd0);
    check("rst_sum",   {48'd0, sum},  64'd0);
    check("rst_cout",  {63'd0, cout}, 64'd0);
    check("rst_ovf",   {63'd0, ovf},  64'd0);
    check("rst_state", {62'd0, state_dbg}, 64'd0);
    check("rst_busy_w", {63'd0, busy_w}, 64'd0);
    check("rst_sum_w",  {32'd0, sum_w},  64'd0);
    rst = 1'b0;

    // Directed adds and subtracts
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1);  // cin must be ignored for sub
    run_op(16'h0000, 16'h0000, 1'b0, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0);

    // Start during RUN and during DONE is ignored, and only one done appears
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_a  = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, 1'b1);
    repeat (6) @(negedge clk);
    check("hold_sum", {48'd0, sum}, 64'h8000);
    check("hold_ovf", {63'd0, ovf}, 64'd1);

    // Reset in mid-RUN aborts the operation without a done pulse
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",  {63'd0, busy}, 64'd0);
    check("abort_sum",   {48'd0, sum},  64'd0);
    check("abort_done",  {63'd0, done}, 64'd0);
    check("abort_state", {62'd0, state_dbg}, 64'd0);
    repeat (6) @(negedge clk);
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0);

    // Random operations
    for (int i = 0; i < 10; i++) begin
      run_op(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // 32-bit instance
    run_op_w(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op_w(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op_w(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_op_w($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    check("exp_q_drained",   exp_q.size(),   64'd0);
    check("exp_w_q_drained", exp_w_q.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
